// File: rtl/dac_word_sequencer.sv
// dac_word_sequencer: per-channel code store and DAC command-word burst generator for a serializer
module dac_word_sequencer #(
  parameter int          NUM_CH       = 8,
  parameter logic [15:0] DEFAULT_CODE = 16'h699A,
  parameter logic [31:0] REF_WORD     = 32'h0800_0001,
  parameter logic [31:0] PD_WORD      = 32'h0400_03FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        powerdown_req,
  input  logic        code_wr_en,
  input  logic [2:0]  code_wr_addr,
  input  logic [15:0] code_wr_data,
  output logic        word_valid,
  output logic [31:0] word_data,
  input  logic        word_ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, REF, CH, PD, FIN} state_t;
  localparam logic [2:0] LAST = 3'(NUM_CH - 1);
  state_t      state;
  logic [2:0]  ch_idx;
  logic [2:0]  next_idx;
  logic [15:0] codes [NUM_CH];
  logic        xfer;
  // Write-and-update command for channel n: cmd 3, address n, code in the data field
  function automatic logic [31:0] chan_word(input logic [2:0] n, input logic [15:0] c);
    return {8'h03, 1'b0, n, c, 4'h0};
  endfunction
  // Handshake completion and the index of the channel word that follows the current one
  always_comb begin
    xfer     = word_valid & word_ready;
    next_idx = ch_idx + 3'd1;
  end
  // Channel code registers; out-of-range addresses are dropped, writes allowed in any state
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) codes[i] <= DEFAULT_CODE;
    end else if (code_wr_en && int'(code_wr_addr) < NUM_CH) begin
      codes[code_wr_addr] <= code_wr_data;
    end
  end
  // Burst sequencer; word_data is captured on state entry or index advance and held through stalls
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ch_idx     <= 3'd0;
      word_valid <= 1'b0;
      word_data  <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (powerdown_req) begin
            state      <= PD;
            word_data  <= PD_WORD;
            word_valid <= 1'b1;
            busy       <= 1'b1;
          end else if (start) begin
            state      <= REF;
            word_data  <= REF_WORD;
            word_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        REF: begin
          if (xfer) begin
            state     <= CH;
            ch_idx    <= 3'd0;
            word_data <= chan_word(3'd0, codes[0]);
          end
        end
        CH: begin
          if (xfer) begin
            if (ch_idx == LAST) begin
              state      <= FIN;
              word_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              ch_idx    <= next_idx;
              word_data <= chan_word(next_idx, codes[next_idx]);
            end
          end
        end
        PD: begin
          if (xfer) begin
            state      <= FIN;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          ch_idx <= 3'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dac_word_sequencer.sv
// tb_dac_word_sequencer: randomized scenario bench checking an 8-channel and a 4-channel sequencer against a word-list model
module tb_dac_word_sequencer;
  localparam logic [31:0] REF_W = 32'h0800_0001;
  localparam logic [31:0] PD_W  = 32'h0400_03FF;
  localparam logic [15:0] DEF   = 16'h699A;
  typedef logic [31:0] wq_t[$];
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        powerdown_req = 1'b0;
  logic        code_wr_en = 1'b0;
  logic [2:0]  code_wr_addr = 3'd0;
  logic [15:0] code_wr_data = 16'h0;
  logic        word_ready = 1'b0;
  logic        v8, b8, dn8, v4, b4, dn4;
  logic [31:0] d8, d4;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int done8 = 0;
  int done4 = 0;
  int done_cyc8 = 0;
  int viol = 0;
  bit pv8 = 0;
  bit pv4 = 0;
  logic [31:0] q8[$];
  logic [31:0] q4[$];
  int          qc8[$];
  logic [15:0] mcode [8];

  dac_word_sequencer dut8 (
    .clk(clk), .reset(reset), .start(start), .powerdown_req(powerdown_req),
    .code_wr_en(code_wr_en), .code_wr_addr(code_wr_addr), .code_wr_data(code_wr_data),
    .word_valid(v8), .word_data(d8), .word_ready(word_ready), .busy(b8), .done(dn8));
  dac_word_sequencer #(.NUM_CH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .powerdown_req(powerdown_req),
    .code_wr_en(code_wr_en), .code_wr_addr(code_wr_addr), .code_wr_data(code_wr_data),
    .word_valid(v4), .word_data(d4), .word_ready(word_ready), .busy(b4), .done(dn4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer log and protocol watch: a word moves when valid and ready are both seen before the edge
  always @(negedge clk) begin
    if (reset) begin
      if (v8 && word_ready) begin q8.push_back(d8); qc8.push_back(cyc); end
      if (v4 && word_ready) q4.push_back(d4);
      if (dn8) begin done8++; done_cyc8 = cyc; end
      if (dn4) done4++;
      if ((dn8 && v8) || (dn4 && v4) || (dn8 && b8) || (dn4 && b4)) viol++;
      if ((pv8 && !v8) || (pv4 && !v4)) viol++;
    end
    pv8 = reset && v8 && !word_ready;
    pv4 = reset && v4 && !word_ready;
  end

  function automatic logic [31:0] chw(input int n, input logic [15:0] c);
    return 32'h0300_0000 + (32'(n) << 20) + (32'(c) << 4);
  endfunction

  function automatic wq_t exp_burst(input int nc);
    wq_t q;
    q.push_back(REF_W);
    for (int n = 0; n < nc; n++) q.push_back(chw(n, mcode[n]));
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    q8.delete(); q4.delete(); qc8.delete();
    done8 = 0; done4 = 0;
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic write_code(input logic [2:0] a, input logic [15:0] d);
    tick(); code_wr_en = 1'b1; code_wr_addr = a; code_wr_data = d;
    tick(); code_wr_en = 1'b0;
    mcode[a] = d;
  endtask

  task automatic wait_done(input bit rnd, input string name);
    int i;
    for (i = 0; i < 400 && !(done8 > 0 && done4 > 0); i++) begin
      tick();
      if (rnd) word_ready = ($urandom_range(0, 3) != 0);
    end
    word_ready = 1'b1;
    if (i == 400) begin
      total++;
      $display("FAIL %s timeout: done8=%0d done4=%0d, required both 1", name, done8, done4);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    total++; if (v8 !== 1'b0) $display("FAIL reset_valid got %b exp 0", v8); else passed++;
    total++; if (d8 !== 32'h0) $display("FAIL reset_data got %h exp 0", d8); else passed++;
    total++; if (b8 !== 1'b0) $display("FAIL reset_busy got %b exp 0", b8); else passed++;
    total++; if (dn8 !== 1'b0) $display("FAIL reset_done got %b exp 0", dn8); else passed++;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) mcode[i] = DEF;
    tick();
  endtask

  task automatic test_burst();
    wq_t e8 = exp_burst(8);
    wq_t e4 = exp_burst(4);
    clr(); word_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    total++; if (v8 !== 1'b1 || b8 !== 1'b1) $display("FAIL burst_latency valid/busy got %b%b exp 11", v8, b8); else passed++;
    wait_done(0, "burst");
    total++; if (q8.size() != 9) $display("FAIL burst_count got %0d exp 9", q8.size()); else passed++;
    for (int i = 0; i < e8.size(); i++) begin
      total++; if (i >= q8.size() || q8[i] !== e8[i]) $display("FAIL burst_word%0d got %h exp %h", i, (i < q8.size()) ? q8[i] : 32'hx, e8[i]); else passed++;
    end
    total++; if (qc8.size() != 9 || qc8[8] - qc8[0] != 8 || done_cyc8 - qc8[0] != 9)
      $display("FAIL burst_timing span=%0d done_at=%0d exp 8/9", (qc8.size() == 9) ? qc8[8] - qc8[0] : -1, (qc8.size() > 0) ? done_cyc8 - qc8[0] : -1);
    else passed++;
    for (int i = 0; i < e4.size(); i++) begin
      total++; if (i >= q4.size() || q4[i] !== e4[i]) $display("FAIL burst4_word%0d got %h exp %h", i, (i < q4.size()) ? q4[i] : 32'hx, e4[i]); else passed++;
    end
  endtask

  task automatic test_code_write();
    wq_t e8, e4;
    for (int k = 0; k < 6; k++) write_code(3'($urandom_range(0, 7)), 16'($urandom));
    write_code(3'd2, 16'h1234);
    write_code(3'd7, 16'($urandom));
    e8 = exp_burst(8); e4 = exp_burst(4);
    clr(); word_ready = 1'b1;
    pulse_start();
    wait_done(1, "code_write");
    total++; if (q8.size() != 9 || q4.size() != 5) $display("FAIL wr_count got %0d/%0d exp 9/5", q8.size(), q4.size()); else passed++;
    total++; if (q8.size() < 4 || q8[3] !== 32'h0321_2340) $display("FAIL wr_ch2 got %h exp 03212340", (q8.size() > 3) ? q8[3] : 32'hx); else passed++;
    for (int i = 0; i < e8.size(); i++) begin
      total++; if (i >= q8.size() || q8[i] !== e8[i]) $display("FAIL wr_word%0d got %h exp %h", i, (i < q8.size()) ? q8[i] : 32'hx, e8[i]); else passed++;
    end
    for (int i = 0; i < e4.size(); i++) begin
      total++; if (i >= q4.size() || q4[i] !== e4[i]) $display("FAIL wr4_word%0d got %h exp %h", i, (i < q4.size()) ? q4[i] : 32'hx, e4[i]); else passed++;
    end
  endtask

  task automatic test_stall();
    wq_t e8 = exp_burst(8);
    logic [15:0] old1 = mcode[1];
    logic [15:0] nw = 16'($urandom) ^ old1 ^ 16'h0101;
    int i;
    clr(); word_ready = 1'b1;
    pulse_start();
    for (i = 0; i < 20 && d8 !== chw(0, mcode[0]); i++) @(negedge clk);
    tick(); word_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (v8 !== 1'b1 || d8 !== chw(1, old1)) $display("FAIL stall_hold%0d got %b/%h exp 1/%h", k, v8, d8, chw(1, old1)); else passed++;
      tick();
      if (k == 1) begin code_wr_en = 1'b1; code_wr_addr = 3'd1; code_wr_data = nw; end
      if (k == 2) code_wr_en = 1'b0;
    end
    mcode[1] = nw;
    word_ready = 1'b1;
    wait_done(0, "stall");
    for (int j = 0; j < e8.size(); j++) begin
      total++; if (j >= q8.size() || q8[j] !== e8[j]) $display("FAIL stall_word%0d got %h exp %h", j, (j < q8.size()) ? q8[j] : 32'hx, e8[j]); else passed++;
    end
    clr();
    pulse_start();
    wait_done(0, "stall_next");
    total++; if (q8.size() < 3 || q8[2] !== chw(1, nw)) $display("FAIL stall_newcode got %h exp %h", (q8.size() > 2) ? q8[2] : 32'hx, chw(1, nw)); else passed++;
  endtask

  task automatic test_pd_priority();
    clr(); word_ready = 1'b1;
    tick(); start = 1'b1; powerdown_req = 1'b1;
    tick(); start = 1'b0; powerdown_req = 1'b0;
    wait_done(0, "pd");
    repeat (10) tick();
    total++; if (q8.size() != 1 || q8[0] !== PD_W) $display("FAIL pd_word count=%0d got %h exp 1/%h", q8.size(), (q8.size() > 0) ? q8[0] : 32'hx, PD_W); else passed++;
    total++; if (done8 != 1 || b8 !== 1'b0) $display("FAIL pd_done done=%0d busy=%b exp 1/0", done8, b8); else passed++;
  endtask

  task automatic test_start_busy();
    clr(); word_ready = 1'b1;
    pulse_start();
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    powerdown_req = 1'b1; tick(); powerdown_req = 1'b0;
    wait_done(0, "start_busy");
    repeat (15) tick();
    total++; if (q8.size() != 9 || done8 != 1) $display("FAIL busy_ignore words=%0d done=%0d exp 9/1", q8.size(), done8); else passed++;
    total++; if (q4.size() != 5 || done4 != 1) $display("FAIL busy_ignore4 words=%0d done=%0d exp 5/1", q4.size(), done4); else passed++;
  endtask

  task automatic test_reset_mid();
    wq_t e8;
    int i;
    for (int k = 0; k < 4; k++) write_code(3'(k), 16'($urandom));
    clr(); word_ready = 1'b1;
    pulse_start();
    for (i = 0; i < 20 && d8 !== chw(2, mcode[2]); i++) @(negedge clk);
    tick(); reset = 1'b0;
    @(negedge clk);
    total++; if (d8 !== chw(3, mcode[3])) $display("FAIL rst_mid_ch3 got %h exp %h", d8, chw(3, mcode[3])); else passed++;
    tick();
    @(negedge clk);
    total++; if (v8 !== 1'b0 || b8 !== 1'b0 || dn8 !== 1'b0) $display("FAIL rst_mid_outputs got v=%b b=%b d=%b exp 000", v8, b8, dn8); else passed++;
    tick(); reset = 1'b1;
    for (int k = 0; k < 8; k++) mcode[k] = DEF;
    e8 = exp_burst(8);
    clr();
    pulse_start();
    wait_done(0, "rst_restart");
    for (int j = 0; j < e8.size(); j++) begin
      total++; if (j >= q8.size() || q8[j] !== e8[j]) $display("FAIL rst_restart_word%0d got %h exp %h", j, (j < q8.size()) ? q8[j] : 32'hx, e8[j]); else passed++;
    end
  endtask

  task automatic test_protocol();
    total++; if (viol != 0) $display("FAIL protocol_violations got %0d exp 0", viol); else passed++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_code_write();
    test_stall();
    test_pd_priority();
    test_start_busy();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
